// File: rtl/pipeline_hazard_unit.sv
// Pipeline interlock controller: load-use stalls, taken-branch squash,
// multi-cycle mul/div tracking for HI/LO readers, and a stall-cycle counter.
module pipeline_hazard_unit #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_uses_rt,
  input  logic        i_id_reads_hilo,
  input  logic        i_id_md_start,
  input  logic        i_ex_memread,
  input  logic [4:0]  i_ex_rw,
  input  logic        i_ex_branch_taken,
  input  logic        i_ex_md_start,
  input  logic        i_ex_md_div,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_md_busy,
  output logic        o_md_done,
  output logic [15:0] o_stall_cnt
);

  localparam int unsigned CW     = $clog2(DIV_CYCLES + 1);
  localparam int unsigned SCNT_W = 16;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [SCNT_W-1:0]   r_stall_cnt;

  logic w_busy;
  logic w_cnt_zero;
  logic w_load_use;
  logic w_md_stall;
  logic w_stall;

  assign w_busy     = (r_state == S_BUSY);
  assign w_cnt_zero = (r_cnt == '0);

  assign w_load_use = i_id_valid & i_ex_memread & (i_ex_rw != 5'd0) &
                      ((i_ex_rw == i_id_rs) | (i_id_uses_rt & (i_ex_rw == i_id_rt)));

  // HI/LO readers and new mul/div ops wait until the done cycle
  assign w_md_stall = i_id_valid & w_busy & ~w_cnt_zero &
                      (i_id_reads_hilo | i_id_md_start);

  assign w_stall = (w_load_use | w_md_stall) & ~i_ex_branch_taken;

  // Mul/div sequencer and stall counter; the running op is older than any branch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ex_md_start) begin
            r_state <= S_BUSY;
            r_cnt   <= i_ex_md_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
          end
        end
        S_BUSY: begin
          if (w_cnt_zero) r_state <= S_IDLE;
          else            r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_stall && (r_stall_cnt != {SCNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
    end
  end

  // Pipeline control: reset, then branch squash, then stall, else run
  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_stall) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  assign o_md_busy   = ~i_rst & w_busy;
  assign o_md_done   = ~i_rst & w_busy & w_cnt_zero;
  assign o_stall_cnt = i_rst ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: expected output vectors are queued
// as each cycle's stimulus is driven and compared at the following falling edge.
module tb_pipeline_hazard_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_id_valid, i_id_uses_rt, i_id_reads_hilo, i_id_md_start;
  logic [4:0]  i_id_rs, i_id_rt, i_ex_rw;
  logic        i_ex_memread, i_ex_branch_taken, i_ex_md_start, i_ex_md_div;
  logic        o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush;
  logic        o_md_busy, o_md_done;
  logic [15:0] o_stall_cnt;

  pipeline_hazard_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_uses_rt(i_id_uses_rt), .i_id_reads_hilo(i_id_reads_hilo),
    .i_id_md_start(i_id_md_start), .i_ex_memread(i_ex_memread),
    .i_ex_rw(i_ex_rw), .i_ex_branch_taken(i_ex_branch_taken),
    .i_ex_md_start(i_ex_md_start), .i_ex_md_div(i_ex_md_div),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_flush(o_id_ex_flush), .o_md_busy(o_md_busy), .o_md_done(o_md_done),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  ctl;   // pc_en, if_id_en, if_id_flush, id_ex_flush
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } obs_t;

  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0001;
  localparam logic [3:0] CTL_BR    = 4'b1111;
  localparam logic [3:0] CTL_RST   = 4'b0011;

  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t exp_q[$];
  obs_t got, expv;

  function automatic obs_t mk(logic [3:0] ctl, logic busy, logic done, logic [15:0] cnt);
    return {ctl, busy, done, cnt};
  endfunction

  function automatic obs_t sample();
    return {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_md_busy, o_md_done, o_stall_cnt};
  endfunction

  task automatic clr_in();
    i_id_valid = 0; i_id_rs = 0; i_id_rt = 0; i_id_uses_rt = 0;
    i_id_reads_hilo = 0; i_id_md_start = 0; i_ex_memread = 0; i_ex_rw = 0;
    i_ex_branch_taken = 0; i_ex_md_start = 0; i_ex_md_div = 0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
    clr_in();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      i_rst = 1;
      i_id_valid = 1; i_id_rs = 5; i_ex_memread = 1; i_ex_rw = 5; i_ex_md_start = 1;
      exp_q.push_back(mk(CTL_RST, 0, 0, 16'd0));
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL reset[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      i_rst = 0;
      if (k == 0) begin
        i_id_valid = 1; i_id_rs = 5; i_ex_memread = 1; i_ex_rw = 5;
        exp_q.push_back(mk(CTL_STALL, 0, 0, 16'd0));
      end else begin
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd1));
      end
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL load_use[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_gating();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      case (k)
        0: begin
          i_id_valid = 1; i_id_rs = 0; i_ex_memread = 1; i_ex_rw = 0;
          exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd1));
        end
        1: begin
          i_id_valid = 1; i_id_rs = 3; i_id_rt = 7; i_id_uses_rt = 0;
          i_ex_memread = 1; i_ex_rw = 7;
          exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd1));
        end
        2: begin
          i_id_valid = 1; i_id_rs = 3; i_id_rt = 7; i_id_uses_rt = 1;
          i_ex_memread = 1; i_ex_rw = 7;
          exp_q.push_back(mk(CTL_STALL, 0, 0, 16'd1));
        end
        default: exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd2));
      endcase
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL gating[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      if (k == 0) begin
        i_id_valid = 1; i_id_rs = 9; i_ex_memread = 1; i_ex_rw = 9; i_ex_branch_taken = 1;
        exp_q.push_back(mk(CTL_BR, 0, 0, 16'd2));
      end else begin
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd2));
      end
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL branch[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_divide();
    for (int k = 0; k <= 33; k++) begin
      next_cycle();
      if (k == 0) begin
        i_ex_md_start = 1; i_ex_md_div = 1;
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd2));
      end else if (k <= 31) begin
        i_id_valid = 1; i_id_reads_hilo = 1;
        exp_q.push_back(mk(CTL_STALL, 1, 0, 16'(2 + k - 1)));
      end else if (k == 32) begin
        i_id_valid = 1; i_id_reads_hilo = 1;
        exp_q.push_back(mk(CTL_RUN, 1, 1, 16'd33));
      end else begin
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd33));
      end
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL divide[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_multiply();
    for (int k = 0; k <= 5; k++) begin
      next_cycle();
      case (k)
        0: begin i_ex_md_start = 1; exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd33)); end
        1: exp_q.push_back(mk(CTL_RUN, 1, 0, 16'd33));
        2: begin
          i_id_valid = 1; i_id_reads_hilo = 1; i_ex_branch_taken = 1;
          exp_q.push_back(mk(CTL_BR, 1, 0, 16'd33));
        end
        3: begin i_id_valid = 1; i_id_reads_hilo = 1; exp_q.push_back(mk(CTL_STALL, 1, 0, 16'd33)); end
        4: begin i_id_valid = 1; i_id_reads_hilo = 1; exp_q.push_back(mk(CTL_RUN, 1, 1, 16'd34)); end
        default: exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd34));
      endcase
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL multiply[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      if (k == 0) begin
        i_ex_md_start = 1; i_id_valid = 1; i_id_md_start = 1;
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd34));
      end else if (k <= 3) begin
        i_id_valid = 1; i_id_md_start = 1;
        exp_q.push_back(mk(CTL_STALL, 1, 0, 16'(34 + k - 1)));
      end else if (k == 4) begin
        i_id_valid = 1; i_id_md_start = 1;
        exp_q.push_back(mk(CTL_RUN, 1, 1, 16'd37));
      end else if (k == 5) begin
        i_ex_md_start = 1;
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd37));
      end else if (k == 6) begin
        i_ex_md_start = 1; i_ex_md_div = 1;
        exp_q.push_back(mk(CTL_RUN, 1, 0, 16'd37));
      end else if (k <= 8) begin
        exp_q.push_back(mk(CTL_RUN, 1, 0, 16'd37));
      end else if (k == 9) begin
        exp_q.push_back(mk(CTL_RUN, 1, 1, 16'd37));
      end else begin
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd37));
      end
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL back_to_back[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  task automatic test_reset_mid_divide();
    for (int k = 0; k <= 40; k++) begin
      next_cycle();
      i_rst = (k == 10);
      if (k == 0) begin
        i_ex_md_start = 1; i_ex_md_div = 1;
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd37));
      end else if (k < 10) begin
        exp_q.push_back(mk(CTL_RUN, 1, 0, 16'd37));
      end else if (k == 10) begin
        exp_q.push_back(mk(CTL_RST, 0, 0, 16'd0));
      end else begin
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'd0));
      end
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL reset_mid_div[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
    i_rst = 0;
  endtask

  task automatic test_saturation();
    for (int k = 0; k <= 65540; k++) begin
      next_cycle();
      if (k < 65540) begin
        i_id_valid = 1; i_id_rs = 12; i_ex_memread = 1; i_ex_rw = 12;
        exp_q.push_back(mk(CTL_STALL, 0, 0, (k > 65535) ? 16'hFFFF : 16'(k)));
      end else begin
        exp_q.push_back(mk(CTL_RUN, 0, 0, 16'hFFFF));
      end
      @(negedge i_clk);
      got = sample(); expv = exp_q.pop_front(); n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL saturation[%0d] got ctl=%b busy=%b done=%b cnt=%0d expected ctl=%b busy=%b done=%b cnt=%0d",
                    k, got.ctl, got.busy, got.done, got.cnt, expv.ctl, expv.busy, expv.done, expv.cnt);
    end
  endtask

  initial begin
    i_rst = 1;
    clr_in();
    test_reset();
    test_load_use();
    test_gating();
    test_branch();
    test_divide();
    test_multiply();
    test_back_to_back();
    test_reset_mid_divide();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Hazard and interlock controller for the 5-stage MIPS pipeline. It drives the PC enable, the IF/ID enable and flush, and the ID/EX bubble (flush) that sequence the decode/execute pipeline register. It detects load-use hazards, squashes wrong-path instructions on a taken branch, and tracks a multi-cycle multiply/divide unit so that HI/LO readers and back-to-back mul/div ops are interlocked. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MUL_CYCLES, 4, multiply latency in cycles (≥1)
- DIV_CYCLES, 32, divide latency in cycles (≥1, ≥ MUL_CYCLES)
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_id_valid  input  1  ID stage holds a real instruction
- i_id_rs  input  5  ID source register rs
- i_id_rt  input  5  ID source register rt
- i_id_uses_rt  input  1  ID instruction reads rt
- i_id_reads_hilo  input  1  ID instruction is mfhi/mflo
- i_id_md_start  input  1  ID instruction is mult/multu/div/divu
- i_ex_memread  input  1  EX instruction is a load
- i_ex_rw  input  5  EX destination register
- i_ex_branch_taken  input  1  branch/jump resolved taken in EX
- i_ex_md_start  input  1  EX instruction starts mul/div
- i_ex_md_div  input  1  with i_ex_md_start: 1 = divide, 0 = multiply
- o_pc_en  output  1  PC update enable
- o_if_id_en  output  1  IF/ID register load enable
- o_if_id_flush  output  1  IF/ID register clear
- o_id_ex_flush  output  1  load bubble (zero controls) into ID/EX
- o_md_busy  output  1  mul/div in progress
- o_md_done  output  1  one-cycle pulse, HI/LO written this cycle
- o_stall_cnt  output  16  saturating count of stall cycles

## Operation
- FSM states: IDLE, BUSY. Down-counter cnt, width $clog2(DIV_CYCLES+1).
- IDLE: i_ex_md_start=1 → BUSY, cnt ← (i_ex_md_div ? DIV_CYCLES : MUL_CYCLES) − 1. i_ex_md_start is ignored in BUSY.
- BUSY: o_md_busy=1. cnt≠0 → cnt−1. cnt=0 → o_md_done=1, next state IDLE.
- load_use = i_id_valid & i_ex_memread & (i_ex_rw≠0) & ((i_ex_rw==i_id_rs) | (i_id_uses_rt & i_ex_rw==i_id_rt)).
- md_stall = i_id_valid & BUSY & (cnt≠0) & (i_id_reads_hilo | i_id_md_start).
- stall = (load_use | md_stall) & ~i_ex_branch_taken.
- Priority 1, branch taken: o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1, o_if_id_en=1. Stall is suppressed. The mul/div FSM continues unaffected because the mul/div op is older.
- Priority 2, stall: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_if_id_flush=0.
- Otherwise: o_pc_en=1, o_if_id_en=1, both flushes 0.
- o_stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF. Branch flush cycles are not counted.
- Reset, including mid-operation: state ← IDLE, cnt ← 0, o_stall_cnt ← 0. A running mul/div is abandoned and no o_md_done is emitted.
- Output values while i_rst=1: o_pc_en=0, o_if_id_en=0, o_if_id_flush=1, o_id_ex_flush=1, o_md_busy=0, o_md_done=0, o_stall_cnt=0.

## Timing
- All control outputs except o_stall_cnt are combinational from inputs and current state, valid in the same cycle.
- Mul/div: start sampled at cycle T; o_md_busy=1 in cycles T+1..T+LAT; o_md_done=1 in cycle T+LAT only. With LAT=1, busy and done coincide in T+1.
- md_stall releases in the done cycle. The stalled HI/LO reader or next mul/div advances to EX at cycle T+LAT+1, when the FSM is IDLE.
- A load-use stall lasts exactly 1 cycle: the bubble removes the load from EX.
- o_stall_cnt updates at the edge that ends a stall cycle.

## Test plan
- Load-use: EX lw with i_ex_rw=5, ID i_id_rs=5 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle (EX bubble) no stall; o_stall_cnt=1.
- Zero register and rt gating: i_ex_rw=0 with rs=0 → no stall. i_ex_rw=7, rt=7, i_id_uses_rt=0 → no stall.
- Branch beats stall: load-use condition plus i_ex_branch_taken=1 → both flushes 1, pc_en=1, o_stall_cnt unchanged.
- Divide interlock: i_ex_md_start, i_ex_md_div=1 at T; mfhi in ID from T+1 → stalled T+1..T+31, released at T+32 with o_md_done=1; o_stall_cnt=31. Multiply: done at T+4.
- Back-to-back mult: second mult held in ID until the done cycle, then starts a new BUSY with no lost or duplicated o_md_done.
- Reset mid-divide at T+10 → busy=0 next cycle, no done pulse; counter saturation checked by forcing 65536+ stall cycles (stays 16'hFFFF).
